// File: rtl/endp_inject_arbiter_pkg.sv
// Shared definitions for the endpoint injection arbiter: default sizing, credit width, FSM states.
package endp_inject_arbiter_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned FPAY_DEF = 32;
    localparam int unsigned V_DEF    = 4;
    localparam int unsigned B_DEF    = 4;
    localparam int unsigned CW_DEF   = $clog2(B_DEF + 1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/endp_inject_arbiter_rr_arbiter_nreq.sv
// Combinational round-robin picker: first request at or after ptr, wrapping, as one-hot + index.
module rr_arbiter_nreq #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NREQw = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQw-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [NREQw-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = (32'(ptr) + off) % NREQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = NREQw'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/endp_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC injection port between NREQ requesters,
// with per-VC credit tracking toward the router local port.
module endp_inject_arbiter
    import endp_inject_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned Fpay  = FPAY_DEF,
    parameter int unsigned V     = V_DEF,
    parameter int unsigned B     = B_DEF,
    parameter int unsigned Vw    = (V > 1) ? $clog2(V) : 1,
    parameter int unsigned NREQw = $clog2(NREQ),
    parameter int unsigned Cw    = $clog2(B + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*Fpay-1:0] req_flit,
    input  logic [NREQ-1:0]      req_hdr,
    input  logic [NREQ-1:0]      req_tail,
    input  logic [NREQ*Vw-1:0]   req_vc,
    output logic [NREQ-1:0]      req_ready,
    output logic                 flit_out_wr,
    output logic [Fpay-1:0]      flit_out,
    output logic                 flit_out_hdr,
    output logic                 flit_out_tail,
    output logic [V-1:0]         flit_out_vc,
    input  logic [V-1:0]         credit_in,
    output logic                 err_credit_ovf,
    output logic                 err_protocol
);

    state_e           state_q, state_d;
    logic [NREQw-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQw-1:0] owner_q, owner_d;
    logic [Vw-1:0]    vc_q, vc_d;
    logic [Cw-1:0]    credit_cnt_q [V];
    logic [V-1:0]     vc_has_credit;

    logic [Vw-1:0]    rvc [NREQ];
    logic [Fpay-1:0]  rflit [NREQ];
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [NREQw-1:0] win_idx;
    logic             win_any;

    logic [NREQ-1:0]  ready;
    logic             accept;
    logic             perr;
    logic [NREQw-1:0] sel_idx;
    logic [Vw-1:0]    send_vc;
    logic [V-1:0]     send_oh;

    always_comb begin
        for (int unsigned v = 0; v < V; v++) begin
            vc_has_credit[v] = (credit_cnt_q[v] != '0);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            rvc[i]      = req_vc[i*Vw +: Vw];
            rflit[i]    = req_flit[i*Fpay +: Fpay];
            eligible[i] = req_valid[i] & req_hdr[i] & vc_has_credit[rvc[i]];
        end
    end

    rr_arbiter_nreq #(
        .NREQ  (NREQ),
        .NREQw (NREQw)
    ) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (win_idx),
        .any       (win_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        vc_d     = vc_q;
        ready    = '0;
        accept   = 1'b0;
        perr     = 1'b0;
        sel_idx  = owner_q;
        send_vc  = vc_q;
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    ready   = grant;
                    accept  = 1'b1;
                    sel_idx = win_idx;
                    send_vc = rvc[win_idx];
                    if (req_tail[win_idx]) begin
                        rr_ptr_d = (win_idx == NREQw'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    end else begin
                        state_d = StBusy;
                        owner_d = win_idx;
                        vc_d    = rvc[win_idx];
                    end
                end
            end
            StBusy: begin
                // A header from the owner mid-packet is refused and flagged, never forwarded.
                if (req_valid[owner_q]) begin
                    if (req_hdr[owner_q]) begin
                        perr = 1'b1;
                    end else if (vc_has_credit[vc_q]) begin
                        ready[owner_q] = 1'b1;
                        accept         = 1'b1;
                        if (req_tail[owner_q]) begin
                            state_d  = StIdle;
                            rr_ptr_d = (owner_q == NREQw'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Keep combinational outputs quiet while reset is held.
    assign req_ready    = ready & {NREQ{reset}};
    assign err_protocol = perr & reset;

    always_comb begin
        send_oh = '0;
        if (accept) begin
            send_oh[send_vc] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            vc_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            vc_q     <= vc_d;
        end
    end

    // Credits are taken at acceptance so the count can never go negative.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < V; v++) begin
                credit_cnt_q[v] <= Cw'(B);
            end
            err_credit_ovf <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < V; v++) begin
                if (send_oh[v] && !credit_in[v]) begin
                    credit_cnt_q[v] <= credit_cnt_q[v] - 1'b1;
                end else if (credit_in[v] && !send_oh[v]) begin
                    if (credit_cnt_q[v] == Cw'(B)) begin
                        err_credit_ovf <= 1'b1;
                    end else begin
                        credit_cnt_q[v] <= credit_cnt_q[v] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_out_wr   <= 1'b0;
            flit_out      <= '0;
            flit_out_hdr  <= 1'b0;
            flit_out_tail <= 1'b0;
            flit_out_vc   <= '0;
        end else begin
            flit_out_wr <= accept;
            if (accept) begin
                flit_out      <= rflit[sel_idx];
                flit_out_hdr  <= req_hdr[sel_idx];
                flit_out_tail <= req_tail[sel_idx];
                flit_out_vc   <= send_oh;
            end
        end
    end

endmodule
